// File: rtl/arrow_field_scan.sv
// arrow_field_scan: walks the velocity grid in row-major order and, for each
// display block, turns the stored Q16.16 velocity into an arrow description
// (origin, unit direction, length) for draw_block.
//
// Magnitude comes from a restoring bit-serial square root (32 cycles).
// Direction comes from two restoring bit-serial dividers (17 cycles).
//
// Optional build macro: ARROW_MAG_CLAMP_EN
//   When defined, the arrow length is clamped to (BLOCK_SIZE-2) pixels so the
//   arrow always fits in its block. Direction is not affected.
module arrow_field_scan #(
  parameter int DRAW_WIDTH  = 320,
  parameter int DRAW_HEIGHT = 240,
  parameter int BLOCK_SIZE  = 40,
  parameter int GRID_W      = DRAW_WIDTH / BLOCK_SIZE,
  parameter int GRID_H      = DRAW_HEIGHT / BLOCK_SIZE,
  parameter int VEL_ADDRW   = $clog2(GRID_W * GRID_H)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [VEL_ADDRW-1:0] vel_addr,
  output logic                 vel_rd,
  input  logic signed [31:0]   vx,
  input  logic signed [31:0]   vy,
  output logic                 block_start,
  input  logic                 block_done,
  output logic [31:0]          block_x,
  output logic [31:0]          block_y,
  output logic signed [31:0]   xn,
  output logic signed [31:0]   yn,
  output logic signed [31:0]   mag
);

  localparam int NBLK = GRID_W * GRID_H;
  localparam int COLW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int ROWW = (GRID_H > 1) ? $clog2(GRID_H) : 1;
  localparam logic [VEL_ADDRW-1:0] LAST_IDX = VEL_ADDRW'(NBLK - 1);
  localparam logic [COLW-1:0]      LAST_COL = COLW'(GRID_W - 1);
  localparam logic [31:0]          UNIT_ONE = 32'h0001_0000;
  localparam logic [4:0]           SQRT_STEPS = 5'd31;
  localparam logic [4:0]           DIV_STEPS  = 5'd16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_SQRT,
    S_DIV,
    S_START,
    S_WAIT
  } state_t;

  state_t          state_reg;
  logic [COLW-1:0] col_reg;
  logic [ROWW-1:0] row_reg;
  logic [4:0]      step_reg;

  // Per-lane operand state: lane 0 is x, lane 1 is y.
  logic        sign_reg    [2];
  logic [31:0] abs_reg     [2];
  logic [31:0] div_rem_reg [2];
  logic [16:0] div_num_reg [2];
  logic [15:0] div_q_reg   [2];

  // Square-root state: radicand shifts out two bits per step.
  logic [63:0] rad_reg;
  logic [35:0] sq_rem_reg;
  logic [31:0] root_reg;

  // Combinational per-lane values.
  logic [31:0] vel_in       [2];
  logic [31:0] sat_in       [2];
  logic [31:0] abs_in       [2];
  logic [63:0] sq_in        [2];
  logic [32:0] div_trial    [2];
  logic        div_ge       [2];
  logic [31:0] div_rem_next [2];
  logic [16:0] div_q_next   [2];
  logic [31:0] dir_next     [2];

  logic [63:0] rad_next;
  logic [35:0] sq_shift;
  logic [35:0] sq_trial;
  logic        sq_ge;
  logic [35:0] sq_rem_next;
  logic [31:0] root_next;
  logic        root_zero;
  logic [31:0] mag_next;
  logic [31:0] bx_next;
  logic [31:0] by_next;

  assign vel_in[0] = vx;
  assign vel_in[1] = vy;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      // -2^31 has no positive counterpart; pull it in by one LSB.
      assign sat_in[gi] = (vel_in[gi] == 32'h8000_0000) ? 32'h8000_0001 : vel_in[gi];
      assign abs_in[gi] = sat_in[gi][31] ? (~sat_in[gi] + 32'd1) : sat_in[gi];
      assign sq_in[gi]  = {32'd0, abs_in[gi]} * {32'd0, abs_in[gi]};

      // Restoring division step: bring down the next numerator bit, subtract
      // the divisor if it fits. abs <= |v| keeps the quotient within 17 bits.
      assign div_trial[gi]    = {div_rem_reg[gi], div_num_reg[gi][16]};
      assign div_ge[gi]       = (div_trial[gi] >= {1'b0, root_reg});
      assign div_rem_next[gi] = div_ge[gi] ? 32'(div_trial[gi] - {1'b0, root_reg})
                                           : div_trial[gi][31:0];
      assign div_q_next[gi]   = {div_q_reg[gi], div_ge[gi]};

      // Zero vector draws a unit arrow along +x (with zero length).
      assign dir_next[gi] = root_zero ? ((gi == 0) ? UNIT_ONE : 32'd0)
                          : (sign_reg[gi] ? (32'd0 - {15'd0, div_q_next[gi]})
                                          : {15'd0, div_q_next[gi]});
    end
  endgenerate

  // Radicand is Q32.32; both squares are < 2^62 so the sum cannot overflow.
  assign rad_next = sq_in[0] + sq_in[1];

  // Restoring square-root step, one result bit per cycle, MSB first.
  assign sq_shift    = (sq_rem_reg << 2) | {34'd0, rad_reg[63:62]};
  assign sq_trial    = {2'b00, root_reg, 2'b01};
  assign sq_ge       = (sq_shift >= sq_trial);
  assign sq_rem_next = sq_ge ? (sq_shift - sq_trial) : sq_shift;
  assign root_next   = {root_reg[30:0], sq_ge};
  assign root_zero   = (root_reg == 32'd0);

`ifdef ARROW_MAG_CLAMP_EN
  localparam logic [31:0] MAG_LIMIT = 32'((BLOCK_SIZE - 2) << 16);
  assign mag_next = (root_reg > MAG_LIMIT) ? MAG_LIMIT : root_reg;
`else
  assign mag_next = root_reg;
`endif

  assign bx_next = (32'(col_reg) * 32'(BLOCK_SIZE)) << 16;
  assign by_next = (32'(row_reg) * 32'(BLOCK_SIZE)) << 16;

  // Magnitude datapath: capture operands in LATCH, then iterate the root.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rad_reg    <= '0;
      sq_rem_reg <= '0;
      root_reg   <= '0;
      for (int i = 0; i < 2; i++) begin
        sign_reg[i] <= 1'b0;
        abs_reg[i]  <= '0;
      end
    end else begin
      case (state_reg)
        S_LATCH: begin
          rad_reg    <= rad_next;
          sq_rem_reg <= '0;
          root_reg   <= '0;
          for (int i = 0; i < 2; i++) begin
            sign_reg[i] <= sat_in[i][31];
            abs_reg[i]  <= abs_in[i];
          end
        end
        S_SQRT: begin
          rad_reg    <= rad_reg << 2;
          sq_rem_reg <= sq_rem_next;
          root_reg   <= root_next;
        end
        default: ;
      endcase
    end
  end

  // Divider lanes: preload on the last root step, then one quotient bit per
  // cycle. Partial remainder starts at abs>>1 since the quotient is <= 2^16.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        div_rem_reg[i] <= '0;
        div_num_reg[i] <= '0;
        div_q_reg[i]   <= '0;
      end
    end else if (state_reg == S_SQRT && step_reg == 5'd0) begin
      for (int i = 0; i < 2; i++) begin
        div_rem_reg[i] <= {1'b0, abs_reg[i][31:1]};
        div_num_reg[i] <= {abs_reg[i][0], 16'h0000};
        div_q_reg[i]   <= '0;
      end
    end else if (state_reg == S_DIV && !root_zero) begin
      for (int i = 0; i < 2; i++) begin
        div_rem_reg[i] <= div_rem_next[i];
        div_num_reg[i] <= div_num_reg[i] << 1;
        div_q_reg[i]   <= div_q_next[i][15:0];
      end
    end
  end

  // Scan sequencer with registered handshake and arrow outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      col_reg     <= '0;
      row_reg     <= '0;
      step_reg    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      vel_addr    <= '0;
      vel_rd      <= 1'b0;
      block_start <= 1'b0;
      block_x     <= '0;
      block_y     <= '0;
      xn          <= '0;
      yn          <= '0;
      mag         <= '0;
    end else begin
      done        <= 1'b0;
      block_start <= 1'b0;
      vel_rd      <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            col_reg   <= '0;
            row_reg   <= '0;
            vel_addr  <= '0;
            vel_rd    <= 1'b1;
            busy      <= 1'b1;
            state_reg <= S_READ;
          end
        end
        S_READ: begin
          state_reg <= S_LATCH;
        end
        S_LATCH: begin
          step_reg  <= SQRT_STEPS;
          state_reg <= S_SQRT;
        end
        S_SQRT: begin
          if (step_reg == 5'd0) begin
            step_reg  <= DIV_STEPS;
            state_reg <= S_DIV;
          end else begin
            step_reg <= step_reg - 5'd1;
          end
        end
        S_DIV: begin
          if (step_reg == 5'd0) begin
            // Final quotient bit is folded in here so the outputs appear
            // together with block_start.
            xn          <= dir_next[0];
            yn          <= dir_next[1];
            mag         <= mag_next;
            block_x     <= bx_next;
            block_y     <= by_next;
            block_start <= 1'b1;
            state_reg   <= S_START;
          end else begin
            step_reg <= step_reg - 5'd1;
          end
        end
        S_START: begin
          state_reg <= S_WAIT;
        end
        S_WAIT: begin
          if (block_done) begin
            if (vel_addr == LAST_IDX) begin
              done      <= 1'b1;
              busy      <= 1'b0;
              state_reg <= S_IDLE;
            end else begin
              if (col_reg == LAST_COL) begin
                col_reg <= '0;
                row_reg <= row_reg + 1'b1;
              end else begin
                col_reg <= col_reg + 1'b1;
              end
              vel_addr  <= vel_addr + 1'b1;
              vel_rd    <= 1'b1;
              state_reg <= S_READ;
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/arrow_field_scan.md
# arrow_field_scan

- Upstream sequencer for `draw_block`.
- Scans the velocity grid in row-major order, one entry per display block.
- For each block it:
  - reads the block's velocity vector;
  - computes the magnitude with a bit-serial square root;
  - computes the unit direction with bit-serial dividers;
  - drives `draw_block` with `block_x/block_y/xn/yn/mag` and a start/done handshake.
- All vector and position values are signed/unsigned Q16.16.

## Interface
- `DRAW_WIDTH`, 320, framebuffer width in pixels
- `DRAW_HEIGHT`, 240, framebuffer height in pixels
- `BLOCK_SIZE`, 40, block edge in pixels
- `GRID_W`, `DRAW_WIDTH/BLOCK_SIZE` (8), blocks per row
- `GRID_H`, `DRAW_HEIGHT/BLOCK_SIZE` (6), block rows
- `VEL_ADDRW`, `$clog2(GRID_W*GRID_H)`, velocity memory address width
- `clk` in 1: single clock; all logic on rising edge
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: one-cycle pulse; begins a full grid scan when idle
- `busy` out 1: high from the cycle after an accepted `start` until `done`
- `done` out 1: one-cycle pulse after the last block completes
- `vel_addr` out VEL_ADDRW: `row*GRID_W+col`
- `vel_rd` out 1: read strobe; data is valid exactly 1 cycle later
- `vx`, `vy` in 32 signed: Q16.16 velocity read data
- `block_start` out 1: one-cycle start pulse to `draw_block`
- `block_done` in 1: done pulse from `draw_block`
- `block_x`, `block_y` out 32: Q16.16 pixel origin, `(col*BLOCK_SIZE)<<16` and `(row*BLOCK_SIZE)<<16`
- `xn`, `yn` out 32 signed: Q16.16 unit direction
- `mag` out 32 signed: Q16.16 arrow length in pixels

## Operation
- **IDLE**
  - On `start`: col=row=0, go to READ.
  - `start` while not IDLE is ignored.
- **READ** (1 cycle): `vel_addr` = current index, `vel_rd`=1.
- **LATCH** (1 cycle)
  - Sample `vx`, `vy`.
  - Saturate -2^31 to -(2^31-1).
  - Store sign bits and absolute values `ax`, `ay`.
- **SQRT** (32 cycles)
  - Radicand R = ax²+ay² (64-bit unsigned; Q32.32).
  - Restoring bit-serial root, one result bit per cycle, MSB first.
  - Result |v| = floor(sqrt(R)), Q16.16, 32 bits.
- **DIV** (17 cycles)
  - Two parallel restoring dividers: qx = floor((ax<<16)/|v|), qy likewise.
  - 17 quotient bits each; result ≤ 0x10000.
  - xn/yn = sign-applied quotient (negate if source negative).
  - Zero vector (|v|=0): skip division; force xn=0x10000, yn=0, mag=0. The block is still drawn, which erases the stale arrow.
  - mag = |v| after optional clamp (see Configuration).
- **START** (1 cycle): `block_start`=1; register `block_x`, `block_y`, `xn`, `yn`, `mag`.
- **WAIT**
  - Hold on `block_done`.
  - Then advance: col+1; at col=GRID_W-1, col=0 and row+1.
  - Go to READ.
  - After block index GRID_W*GRID_H-1: pulse `done`, return to IDLE.
- `block_done` outside WAIT is ignored. `block_done` in the same cycle as START is not possible and need not be handled.
- **Reset:** any state goes to IDLE. All outputs become 0 (`xn`, `yn`, `mag`, `block_x`, `block_y`, `vel_addr` = 0; all strobes low).
  - Reset mid-scan aborts without `done`.
  - `draw_block` is not reset by this block.

## Timing
- READ entry = cycle 0 → LATCH 1 → SQRT 2..33 → DIV 34..50 → `block_start` at cycle 51.
- Zero vector takes the same 51 cycles; DIV idles.
- `block_x`, `block_y`, `xn`, `yn`, `mag` change only in the START cycle. They are stable from `block_start` through `block_done`, because `draw_block` uses them combinationally.
- READ for the next block is 1 cycle after `block_done`.
- `done` is 1 cycle after the final `block_done`. `busy` falls in the same cycle as `done`.
- Full-scan time = 48 × (53 + draw_block latency) cycles at defaults.

## Configuration
- **`ARROW_MAG_CLAMP_EN` defined:**
  - mag = min(|v|, (BLOCK_SIZE-2)<<16).
  - The arrow always fits inside its block.
  - Direction is unaffected.
- **`ARROW_MAG_CLAMP_EN` undefined:** mag = |v| unmodified.

## Test plan
- vx=0x30000, vy=0x40000 at index 0 → mag=0x50000, xn=0x9999, yn=0xCCCC, block_x=block_y=0, `block_start` 51 cycles after `vel_rd`.
- vx=0xFFFF0000 (-1.0), vy=0 → mag=0x10000, xn=0xFFFF0000, yn=0.
- vx=vy=0 → xn=0x10000, yn=0, mag=0; `block_start` still issued.
- vx=0x640000, vy=0:
  - with `ARROW_MAG_CLAMP_EN` → mag=0x260000;
  - without → mag=0x640000;
  - xn=0x10000 in both.
- Full scan with a `draw_block` model (random done latency 1-20) and a second `start` mid-scan:
  - exactly 48 `block_start` pulses;
  - 48th has `vel_addr`=47, block_x=0x1180000, block_y=0xC80000;
  - single `done` 1 cycle after 48th `block_done`;
  - second `start` ignored.
- Assert `rst` during SQRT of block 5:
  - all outputs 0 next edge, no `done`;
  - subsequent `start` reads index 0 first.
